// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads imem combinationally, and fills the IF/ID register.
// Optional MIPS branch delay slot behaviour is enabled with `define IF_STAGE_DELAY_SLOT_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_target_i,
   input  logic        halt_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   output logic        id_valid_o,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_pc_plus4_o,
   output logic        halted_o,
   output logic        misaligned_o,
   output logic [31:0] fetch_count_o
);

   localparam int unsigned XLEN = 32;

   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   pc_plus4;
   logic              id_valid_d;
   logic [XLEN-1:0]   id_instr_d, id_pc_d, id_pc_plus4_d;
   logic              misaligned_d;
   logic [XLEN-1:0]   fetch_count_d;
`ifdef IF_STAGE_DELAY_SLOT_EN
   logic              pend_valid_q, pend_valid_d;
   logic [XLEN-1:0]   pend_target_q, pend_target_d;
   logic              take_redirect;
   logic [XLEN-1:0]   take_target;
`endif

   assign pc_plus4    = pc_q + XLEN'(4);
   assign imem_addr_o = pc_q;
   assign halted_o    = (state_q == ST_HALTED);

`ifdef IF_STAGE_DELAY_SLOT_EN
   // A fresh redirect supersedes any redirect left pending from a stall.
   always_comb begin
      take_redirect = redirect_valid_i | pend_valid_q;
      take_target   = redirect_valid_i ? redirect_target_i : pend_target_q;
   end
`endif

   // Next-state and next-output logic; everything holds unless a case below updates it.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      id_valid_d    = id_valid_o;
      id_instr_d    = id_instr_o;
      id_pc_d       = id_pc_o;
      id_pc_plus4_d = id_pc_plus4_o;
      misaligned_d  = misaligned_o;
      fetch_count_d = fetch_count_o;
`ifdef IF_STAGE_DELAY_SLOT_EN
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
`endif

      case (state_q)
         ST_RUN: begin
            if (halt_i) begin
               state_d       = ST_HALTED;
               id_valid_d    = 1'b0;
               id_instr_d    = NOP_WORD;
               id_pc_d       = pc_q;
               id_pc_plus4_d = pc_plus4;
`ifdef IF_STAGE_DELAY_SLOT_EN
               pend_valid_d  = 1'b0;
`endif
            end else begin
`ifdef IF_STAGE_DELAY_SLOT_EN
               if (!stall_i) begin
                  id_valid_d    = 1'b1;
                  id_instr_d    = imem_rdata_i;
                  id_pc_d       = pc_q;
                  id_pc_plus4_d = pc_plus4;
                  fetch_count_d = fetch_count_o + XLEN'(1);
                  pend_valid_d  = 1'b0;
                  if (take_redirect) begin
                     pc_d = {take_target[XLEN-1:2], 2'b00};
                     if (take_target[1:0] != 2'b00) misaligned_d = 1'b1;
                  end else begin
                     pc_d = pc_plus4;
                  end
               end else if (redirect_valid_i) begin
                  pend_valid_d  = 1'b1;
                  pend_target_d = redirect_target_i;
               end
`else
               // Redirect wins over stall and squashes the wrong-path fetch.
               if (redirect_valid_i) begin
                  pc_d          = {redirect_target_i[XLEN-1:2], 2'b00};
                  id_valid_d    = 1'b0;
                  id_instr_d    = NOP_WORD;
                  id_pc_d       = pc_q;
                  id_pc_plus4_d = pc_plus4;
                  if (redirect_target_i[1:0] != 2'b00) misaligned_d = 1'b1;
               end else if (!stall_i) begin
                  pc_d          = pc_plus4;
                  id_valid_d    = 1'b1;
                  id_instr_d    = imem_rdata_i;
                  id_pc_d       = pc_q;
                  id_pc_plus4_d = pc_plus4;
                  fetch_count_d = fetch_count_o + XLEN'(1);
               end
`endif
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         id_valid_o    <= 1'b0;
         id_instr_o    <= NOP_WORD;
         id_pc_o       <= XLEN'(0);
         id_pc_plus4_o <= XLEN'(4);
         misaligned_o  <= 1'b0;
         fetch_count_o <= XLEN'(0);
`ifdef IF_STAGE_DELAY_SLOT_EN
         pend_valid_q  <= 1'b0;
         pend_target_q <= XLEN'(0);
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         id_valid_o    <= id_valid_d;
         id_instr_o    <= id_instr_d;
         id_pc_o       <= id_pc_d;
         id_pc_plus4_o <= id_pc_plus4_d;
         misaligned_o  <= misaligned_d;
         fetch_count_o <= fetch_count_d;
`ifdef IF_STAGE_DELAY_SLOT_EN
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
`endif
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed plan steps followed by randomized stall/redirect/halt/reset traffic
// checked against a cycle-level reference model.
module tb_if_stage;

   logic        clock;
   logic        reset;
   logic        stall_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_target_i;
   logic        halt_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        id_valid_o;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_pc_plus4_o;
   logic        halted_o;
   logic        misaligned_o;
   logic [31:0] fetch_count_o;

   int errors = 0;
   int checks = 0;

   if_stage dut (
      .clock             (clock),
      .reset             (reset),
      .stall_i           (stall_i),
      .redirect_valid_i  (redirect_valid_i),
      .redirect_target_i (redirect_target_i),
      .halt_i            (halt_i),
      .imem_addr_o       (imem_addr_o),
      .imem_rdata_i      (imem_rdata_i),
      .id_valid_o        (id_valid_o),
      .id_instr_o        (id_instr_o),
      .id_pc_o           (id_pc_o),
      .id_pc_plus4_o     (id_pc_plus4_o),
      .halted_o          (halted_o),
      .misaligned_o      (misaligned_o),
      .fetch_count_o     (fetch_count_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction memory: a fixed word at the reset vector, an address-derived pattern elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_3000) return 32'h2408_0001;
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   assign imem_rdata_i = mem_word(imem_addr_o);

   // Reference model state.
   logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_count;
   logic        m_valid, m_halted, m_mis;
   logic        m_pend;
   logic [31:0] m_pend_tgt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_fetch();
      m_valid = 1'b1;
      m_instr = mem_word(m_pc);
      m_idpc  = m_pc;
      m_idpc4 = m_pc + 32'd4;
      m_count = m_count + 32'd1;
   endtask

   task automatic model_jump(input logic [31:0] t);
      m_pc = t & 32'hFFFF_FFFC;
      if (t % 4 != 0) m_mis = 1'b1;
   endtask

   task automatic model_step(input logic r, input logic s, input logic rv,
                             input logic [31:0] rt, input logic h);
      if (r) begin
         m_pc = 32'h3000; m_valid = 1'b0; m_instr = 32'h0; m_idpc = 32'h0; m_idpc4 = 32'h4;
         m_count = 32'h0; m_halted = 1'b0; m_mis = 1'b0; m_pend = 1'b0;
      end else if (m_halted) begin
         // frozen until reset
      end else if (h) begin
         m_halted = 1'b1; m_valid = 1'b0; m_instr = 32'h0; m_pend = 1'b0;
      end else begin
`ifdef IF_STAGE_DELAY_SLOT_EN
         if (s) begin
            if (rv) begin m_pend = 1'b1; m_pend_tgt = rt; end
         end else begin
            logic [31:0] next_pc;
            next_pc = m_pc + 32'd4;
            model_fetch();
            if (rv) model_jump(rt);
            else if (m_pend) model_jump(m_pend_tgt);
            else m_pc = next_pc;
            m_pend = 1'b0;
         end
`else
         if (rv) begin
            m_valid = 1'b0; m_instr = 32'h0; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
            model_jump(rt);
         end else if (!s) begin
            model_fetch();
            m_pc = m_pc + 32'd4;
         end
`endif
      end
   endtask

   task automatic compare_all();
      check("imem_addr", imem_addr_o, m_pc);
      check("id_valid", 32'(id_valid_o), 32'(m_valid));
      check("id_instr", id_instr_o, m_instr);
      // IF/ID pc fields are only meaningful while fetching
      if (!m_halted) begin
         check("id_pc", id_pc_o, m_idpc);
         check("id_pc_plus4", id_pc_plus4_o, m_idpc4);
      end
      check("halted", 32'(halted_o), 32'(m_halted));
      check("misaligned", 32'(misaligned_o), 32'(m_mis));
      check("fetch_count", fetch_count_o, m_count);
   endtask

   // One clock: drive inputs, advance model, sample 1 time unit after the edge.
   task automatic tick(input logic r, input logic s, input logic rv,
                       input logic [31:0] rt, input logic h);
      reset = r; stall_i = s; redirect_valid_i = rv; redirect_target_i = rt; halt_i = h;
      model_step(r, s, rv, rt, h);
      @(posedge clock);
      #1;
      compare_all();
   endtask

   initial begin
      reset = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = 32'h0; halt_i = 1'b0;
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_idpc = 32'h0; m_idpc4 = 32'h0;
      m_count = 32'h0; m_halted = 1'b0; m_mis = 1'b0; m_pend = 1'b0; m_pend_tgt = 32'h0;

      // Reset and first fetch
      tick(1, 0, 0, 32'h0, 0);
      check("rst_addr", imem_addr_o, 32'h3000);
      check("rst_valid", 32'(id_valid_o), 32'h0);
      tick(0, 0, 0, 32'h0, 0);
      check("first_instr", id_instr_o, 32'h2408_0001);
      check("first_pc", id_pc_o, 32'h3000);
      check("first_pc4", id_pc_plus4_o, 32'h3004);
      check("first_count", fetch_count_o, 32'd1);

      // Sequential then 2-cycle stall
      tick(0, 0, 0, 32'h0, 0);
      tick(0, 0, 0, 32'h0, 0);
      for (int i = 0; i < 2; i++) begin
         tick(0, 1, 0, 32'h0, 0);
         check("stall_addr", imem_addr_o, 32'h300C);
         check("stall_pc", id_pc_o, 32'h3008);
         check("stall_count", fetch_count_o, 32'd3);
      end
      tick(0, 0, 0, 32'h0, 0);
      check("release_pc", id_pc_o, 32'h300C);

`ifdef IF_STAGE_DELAY_SLOT_EN
      // Delay slot: redirect fetches the slot instruction, then jumps
      tick(0, 0, 1, 32'h3040, 0);
      check("ds_pc", id_pc_o, 32'h3010);
      check("ds_valid", 32'(id_valid_o), 32'h1);
      check("ds_addr", imem_addr_o, 32'h3040);
      tick(0, 0, 0, 32'h0, 0);
      check("ds_tgt_pc", id_pc_o, 32'h3040);
      // Redirect during stall is held pending
      tick(1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) tick(0, 0, 0, 32'h0, 0);
      tick(0, 1, 1, 32'h3040, 0);
      check("pend_hold", imem_addr_o, 32'h3010);
      tick(0, 1, 0, 32'h0, 0);
      check("pend_hold2", imem_addr_o, 32'h3010);
      tick(0, 0, 0, 32'h0, 0);
      check("pend_jump", imem_addr_o, 32'h3040);
      check("pend_slot_pc", id_pc_o, 32'h3010);
`else
      // Redirect overrides stall and flushes IF/ID
      tick(0, 1, 1, 32'h3040, 0);
      check("redir_addr", imem_addr_o, 32'h3040);
      check("redir_valid", 32'(id_valid_o), 32'h0);
      check("redir_instr", id_instr_o, 32'h0);
      tick(0, 0, 0, 32'h0, 0);
      check("redir_tgt_pc", id_pc_o, 32'h3040);
`endif

      // Misaligned target rounds down and sets the sticky flag
      tick(0, 0, 1, 32'h3042, 0);
      tick(0, 0, 0, 32'h0, 0);
      check("mis_flag", 32'(misaligned_o), 32'h1);
      check("mis_pc", id_pc_o, 32'h3040);
      tick(0, 0, 1, 32'h3100, 0);
      tick(0, 0, 0, 32'h0, 0);
      check("mis_sticky", 32'(misaligned_o), 32'h1);

      // Halt at 0x3020
      tick(1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 8; i++) tick(0, 0, 0, 32'h0, 0);
      check("pre_halt_addr", imem_addr_o, 32'h3020);
      tick(0, 0, 0, 32'h0, 1);
      check("halt_flag", 32'(halted_o), 32'h1);
      check("halt_addr", imem_addr_o, 32'h3020);
      check("halt_valid", 32'(id_valid_o), 32'h0);
      check("halt_count", fetch_count_o, 32'd8);
      tick(0, 0, 1, 32'h3400, 0);
      check("halt_ignore_redir", imem_addr_o, 32'h3020);
      tick(1, 0, 0, 32'h0, 0);
      check("unhalt_addr", imem_addr_o, 32'h3000);
      check("unhalt_flag", 32'(halted_o), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic        r, s, rv, h;
         logic [31:0] rt;
         r  = ($urandom_range(0, 63) == 0);
         h  = ($urandom_range(0, 59) == 0);
         rv = ($urandom_range(0, 5) == 0);
         s  = ($urandom_range(0, 3) == 0);
         rt = {16'h0000, 16'($urandom)};
         if ($urandom_range(0, 49) == 0) rt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
         tick(r, s, rv, rt, h);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core, directly upstream of decode inside Toplevel.
- Owns the PC register and drives a combinational instruction-memory read address.
- Registers the fetched word into the IF/ID pipeline register.
- Honours stall, redirect (branch/jump) and halt (syscall) requests from later stages.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction word placed in IF/ID when empty or flushed.

Ports:
clock  input  1  system clock, all state updates on posedge.
reset  input  1  synchronous, active-high reset.
stall_i  input  1  hazard unit: hold PC and IF/ID contents.
redirect_valid_i  input  1  later stage requests PC change this cycle.
redirect_target_i  input  32  new PC for redirect.
halt_i  input  1  decode saw syscall; stop fetching.
imem_addr_o  output  32  instruction memory byte address (= PC).
imem_rdata_i  input  32  combinational instruction word at imem_addr_o.
id_valid_o  output  1  IF/ID holds a real instruction.
id_instr_o  output  32  IF/ID instruction.
id_pc_o  output  32  PC of id_instr_o.
id_pc_plus4_o  output  32  id_pc_o + 4.
halted_o  output  1  sticky: fetch stopped by halt.
misaligned_o  output  1  sticky: a redirect target had bits [1:0] != 0.
fetch_count_o  output  32  number of instructions written valid into IF/ID.

Behaviour:
- Reset (synchronous, priority over everything):
  - PC = RESET_PC.
  - id_valid_o = 0, id_instr_o = NOP_WORD, id_pc_o = 0, id_pc_plus4_o = 4.
  - halted_o = 0, misaligned_o = 0, fetch_count_o = 0, pending redirect cleared.
- imem_addr_o = PC, combinationally. Memory has zero latency, so fetch-to-ID latency is 1 cycle.
- Per-cycle priority: reset > halted/halt_i > redirect > stall > normal.
- Normal:
  - PC <= PC+4 (32-bit wrap, 0xFFFF_FFFC -> 0).
  - IF/ID <= {1, imem_rdata_i, PC, PC+4}.
  - fetch_count_o increments.
- Stall: PC, IF/ID and fetch_count_o hold.
- Redirect (feature macro undefined):
  - PC <= {target[31:2],2'b00}.
  - IF/ID flushed to {0, NOP_WORD, PC, PC+4}; fetch_count_o holds.
  - Applies even when stall_i is high: redirect overrides stall.
- Misaligned target: misaligned_o set (sticky until reset); the target is still used, rounded down to a word.
- Halt:
  - The cycle halt_i is high, halted_o <= 1; PC frozen.
  - IF/ID flushed to invalid NOP; redirect and stall are ignored.
  - Remains so until reset. halt_i together with redirect: halt wins.
- fetch_count_o wraps at 2^32.
- Reset asserted mid-stall or mid-halt: the normal reset state is restored next cycle, and fetching resumes from RESET_PC the cycle after reset deasserts.

Optional Feature:
- Macro: IF_STAGE_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - A redirect does not flush IF/ID. The instruction fetched in the redirect cycle enters IF/ID valid (normal update), and PC <= target.
  - If redirect_valid_i arrives while stall_i is high, target and valid are latched into a pending register and PC/IF/ID hold.
  - On the first non-stall cycle the pending redirect is applied as above and cleared.
  - A new redirect in that cycle supersedes the pending one.
  - halt or reset clears the pending redirect.
- Undefined: the flush behaviour above. No pending register exists.

Test Plan:
1. Reset: hold reset 1 cycle, imem returns 0x2408_0001 at 0x3000 -> after reset imem_addr_o=0x3000, id_valid_o=0. Next posedge: id_instr_o=0x2408_0001, id_pc_o=0x3000, id_pc_plus4_o=0x3004, fetch_count_o=1.
2. Sequential and stall: 3 free cycles then stall_i=1 for 2 cycles. Required: imem_addr_o=0x300C during the stall and id_pc_o=0x3008 held, fetch_count_o=3 held. After release, id_pc_o=0x300C.
3. Redirect (no macro): at PC=0x3010 assert redirect to 0x3040 with stall_i=1 -> next cycle PC=0x3040, id_valid_o=0, id_instr_o=0. Following cycle id_pc_o=0x3040.
4. Delay slot (macro defined): redirect to 0x3040 at PC=0x3010 -> id_pc_o=0x3010 valid, then 0x3040. Redirect during a 2-cycle stall -> PC holds 0x3010 until release, then jumps to 0x3040.
5. Misaligned: redirect to 0x3042 -> misaligned_o=1, PC=0x3040. The flag stays set after further redirects until reset.
6. Halt: halt_i=1 for one cycle at PC=0x3020 -> halted_o=1, PC stays 0x3020, id_valid_o=0, fetch_count_o frozen. A redirect afterwards is ignored. reset then returns PC to 0x3000 and halted_o to 0.
